// File: rtl/axil_master_seq_pkg.sv
// Shared definitions for the AXI4-Lite master sequencer: response codes,
// AxPROT bit positions and the sequencer state encoding.
package axil_master_seq_pkg;

  // AXI xRESP codes
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // AxPROT bit positions: {instr, nonsecure, privileged}
  localparam int unsigned PROT_PRIV   = 0;
  localparam int unsigned PROT_NONSEC = 1;
  localparam int unsigned PROT_INSTR  = 2;

  // Sequencer states; encodings 6 and 7 are unused and recover to idle
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

endpackage

// File: rtl/axil_master_seq.sv
// Single-outstanding AXI4-Lite master sequencer. One command is accepted in
// idle, driven onto the AW/W or AR channel, and its B or R result is returned
// on the response port. DATA_W must be 32 or 64.
module axil_master_seq
  import axil_master_seq_pkg::*;
#(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_prot,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [STRB_W-1:0] cmd_wstrb,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  // AW channel
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [2:0]        AWPROT,
  // W channel
  output logic              WVALID,
  input  logic              WREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic [STRB_W-1:0] WSTRB,
  // B channel
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  // AR channel
  output logic              ARVALID,
  input  logic              ARREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [2:0]        ARPROT,
  // R channel
  input  logic              RVALID,
  output logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP
);

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          prot_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          resp_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic                rsp_valid_q;
  logic                aw_done;
  logic                w_done;

  // Command port is open only while idle
  always_comb begin
    cmd_ready = (state == ST_IDLE);
  end

  // Channel payloads come straight from the captured command
  assign AWADDR    = addr_q;
  assign AWPROT    = prot_q;
  assign ARADDR    = addr_q;
  assign ARPROT    = prot_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign AWVALID   = awvalid_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  // Sequencer FSM; every handshake output is a register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      prot_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            prot_q  <= cmd_prot;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (cmd_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= ST_WR_AW_W;
            end else begin
              arvalid_q <= 1'b1;
              state     <= ST_RD_AR;
            end
          end
        end

        ST_WR_AW_W: begin
          if (awvalid_q && AWREADY) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (wvalid_q && WREADY) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          // Either channel may finish in this cycle or have finished earlier
          if ((aw_done || (awvalid_q && AWREADY)) &&
              (w_done  || (wvalid_q  && WREADY))) begin
            bready_q <= 1'b1;
            state    <= ST_WR_B;
          end
        end

        ST_WR_B: begin
          if (BVALID && bready_q) begin
            resp_q      <= BRESP;
            rdata_q     <= '0;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RD_AR: begin
          if (arvalid_q && ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_RD_R;
          end
        end

        ST_RD_R: begin
          if (RVALID && rready_q) begin
            rdata_q     <= RDATA;
            resp_q      <= RRESP;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          awvalid_q   <= 1'b0;
          wvalid_q    <= 1'b0;
          bready_q    <= 1'b0;
          arvalid_q   <= 1'b0;
          rready_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_seq.sv
// Bench for axil_master_seq: a delay-programmable AXI4-Lite slave with a
// word memory, a negedge protocol monitor, and a flat reference memory that
// predicts every response.
module tb_axil_master_seq;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_prot;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  axil_master_seq #(.ADDR_W(32), .DATA_W(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_prot(cmd_prot), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
  );

  always #5 ACLK = ~ACLK;
  always @(posedge ACLK) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  slv_bresp = 2'd0, slv_rresp = 2'd0;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_awprot, s_arprot;
  logic [31:0] slave_mem [16] = '{default: 32'h0};
  logic [31:0] ref_mem   [16] = '{default: 32'h0};

  assign AWREADY = AWVALID && !aw_got && (aw_cnt >= aw_delay);
  assign WREADY  = WVALID  && !w_got  && (w_cnt  >= w_delay);
  assign ARREADY = ARVALID && (ar_cnt >= ar_delay);

  function automatic int widx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  function automatic logic [31:0] slv_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      BVALID <= 1'b0; RVALID <= 1'b0; BRESP <= 2'd0; RRESP <= 2'd0; RDATA <= 32'h0;
      s_awaddr <= 32'h0; s_wdata <= 32'h0; s_araddr <= 32'h0; s_wstrb <= 4'h0;
      s_awprot <= 3'h0; s_arprot <= 3'h0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_got <= 1'b1; aw_cnt <= 0; s_awaddr <= AWADDR; s_awprot <= AWPROT;
      end else if (AWVALID && !aw_got) aw_cnt <= aw_cnt + 1;
      if (WVALID && WREADY) begin
        w_got <= 1'b1; w_cnt <= 0; s_wdata <= WDATA; s_wstrb <= WSTRB;
      end else if (WVALID && !w_got) w_cnt <= w_cnt + 1;
      if ((aw_got || (AWVALID && AWREADY)) && (w_got || (WVALID && WREADY)) && !b_pend) begin
        slave_mem[widx(aw_got ? s_awaddr : AWADDR)] <=
          slv_merge(slave_mem[widx(aw_got ? s_awaddr : AWADDR)],
                    w_got ? s_wdata : WDATA, w_got ? s_wstrb : WSTRB);
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1; BRESP <= slv_bresp;
        if (b_delay == 0) BVALID <= 1'b1; else b_cnt <= b_delay;
      end
      if (b_pend && !BVALID) begin
        if (b_cnt <= 1) BVALID <= 1'b1;
        b_cnt <= b_cnt - 1;
      end
      if (BVALID && BREADY) begin BVALID <= 1'b0; b_pend <= 1'b0; end

      if (ARVALID && ARREADY) begin
        ar_cnt <= 0; s_araddr <= ARADDR; s_arprot <= ARPROT;
        RDATA <= slave_mem[widx(ARADDR)]; RRESP <= slv_rresp; r_pend <= 1'b1;
        if (r_delay == 0) RVALID <= 1'b1; else r_cnt <= r_delay;
      end else if (ARVALID) ar_cnt <= ar_cnt + 1;
      if (r_pend && !RVALID) begin
        if (r_cnt <= 1) RVALID <= 1'b1;
        r_cnt <= r_cnt - 1;
      end
      if (RVALID && RREADY) begin RVALID <= 1'b0; r_pend <= 1'b0; end
    end
  end

  // ---------------- protocol monitor ----------------
  int          viol = 0;
  int          awv_hi = 0, wv_hi = 0, arstall = 0, bready_hi = 0;
  logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  logic [2:0]  p_awprot, p_arprot;

  // VALID held and payload stable until handshake; VALID gone right after it
  always @(negedge ACLK) begin
    if (ARESET) begin
      p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
    end else begin
      viol <= viol
        + ((p_awv && !p_awr && (AWVALID !== 1'b1 || AWADDR !== p_awaddr || AWPROT !== p_awprot)) ? 1 : 0)
        + ((p_wv  && !p_wr  && (WVALID  !== 1'b1 || WDATA  !== p_wdata  || WSTRB  !== p_wstrb))  ? 1 : 0)
        + ((p_arv && !p_arr && (ARVALID !== 1'b1 || ARADDR !== p_araddr || ARPROT !== p_arprot)) ? 1 : 0)
        + ((p_awv && p_awr && AWVALID) ? 1 : 0)
        + ((p_wv  && p_wr  && WVALID)  ? 1 : 0)
        + ((p_arv && p_arr && ARVALID) ? 1 : 0);
      p_awv <= AWVALID; p_awr <= AWREADY; p_awaddr <= AWADDR; p_awprot <= AWPROT;
      p_wv  <= WVALID;  p_wr  <= WREADY;  p_wdata  <= WDATA;  p_wstrb  <= WSTRB;
      p_arv <= ARVALID; p_arr <= ARREADY; p_araddr <= ARADDR; p_arprot <= ARPROT;
      awv_hi    <= awv_hi    + (AWVALID ? 1 : 0);
      wv_hi     <= wv_hi     + (WVALID  ? 1 : 0);
      arstall   <= arstall   + ((ARVALID && !ARREADY) ? 1 : 0);
      bready_hi <= bready_hi + (BREADY  ? 1 : 0);
    end
  end

  // ---------------- command driver ----------------
  // hold < 0 leaves the response pending for the caller
  task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [2:0] p,
                        input logic [31:0] d, input logic [3:0] s, input int hold,
                        output logic [31:0] rd, output logic [1:0] rs,
                        output int lat, output bit ok);
    int n;
    int acc;
    ok = 1'b1; lat = 0; rd = '0; rs = '0;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_prot = p;
    cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge ACLK); n++; end
    if (cmd_ready !== 1'b1) begin cmd_valid = 1'b0; ok = 1'b0; return; end
    acc = cyc;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    if (rsp_valid !== 1'b1) begin ok = 1'b0; return; end
    lat = cyc - acc; rd = rsp_rdata; rs = rsp_resp;
    if (hold >= 0) begin
      repeat (hold) @(negedge ACLK);
      rsp_ready = 1'b1;
      @(negedge ACLK);
      rsp_ready = 1'b0;
    end
  endtask

  logic [31:0] rd;
  logic [1:0]  rs;
  int          lat;
  bit          ok;

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(negedge ACLK);
    compared++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready} !== 7'b0000001) begin
      mismatched++;
      $display("FAIL reset_handshake: got %b expected 0000001",
               {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready});
    end
    compared++;
    if ({AWADDR, WDATA, rsp_rdata} !== 96'h0) begin
      mismatched++;
      $display("FAIL reset_regs: AWADDR=%h WDATA=%h rdata=%h expected 0", AWADDR, WDATA, rsp_rdata);
    end
    ARESET = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_write_basic();
    do_cmd(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 4'hF, 0, rd, rs, lat, ok);
    ref_mem[4] = ref_merge(ref_mem[4], 32'hDEAD_BEEF, 4'hF);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL wr_basic_timeout: ok=%0d expected 1", ok); end
    compared++;
    if (lat !== 3) begin mismatched++; $display("FAIL wr_basic_latency: got %0d expected 3", lat); end
    compared++;
    if (rs !== 2'd0 || rd !== 32'h0) begin
      mismatched++; $display("FAIL wr_basic_rsp: resp=%0d rdata=%h expected 0/0", rs, rd);
    end
    compared++;
    if (s_awaddr !== 32'h10 || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'hF || s_awprot !== 3'b010) begin
      mismatched++;
      $display("FAIL wr_basic_payload: addr=%h data=%h strb=%h prot=%b expected 10/deadbeef/f/010",
               s_awaddr, s_wdata, s_wstrb, s_awprot);
    end
  endtask

  task automatic test_read_stall();
    int st0;
    do_cmd(1'b1, 32'h14, 3'b000, 32'h1234_5678, 4'hF, 0, rd, rs, lat, ok);
    ref_mem[5] = ref_merge(ref_mem[5], 32'h1234_5678, 4'hF);
    ar_delay = 4;
    st0 = arstall;
    do_cmd(1'b0, 32'h14, 3'b101, 32'h0, 4'h0, 0, rd, rs, lat, ok);
    ar_delay = 0;
    compared++;
    if (arstall - st0 !== 4) begin
      mismatched++; $display("FAIL rd_stall_cycles: got %0d expected 4", arstall - st0);
    end
    compared++;
    if (!ok || lat !== 7) begin
      mismatched++; $display("FAIL rd_stall_latency: ok=%0d lat=%0d expected 1/7", ok, lat);
    end
    compared++;
    if (rd !== ref_mem[5] || rs !== 2'd0) begin
      mismatched++; $display("FAIL rd_stall_data: got %h/%0d expected %h/0", rd, rs, ref_mem[5]);
    end
    compared++;
    if (s_araddr !== 32'h14 || s_arprot !== 3'b101) begin
      mismatched++; $display("FAIL rd_stall_addr: got %h/%b expected 14/101", s_araddr, s_arprot);
    end
  endtask

  task automatic test_aw_w_order();
    int a0, w0, b0;
    logic [31:0] d;
    for (int k = 0; k < 2; k++) begin
      aw_delay = (k == 0) ? 3 : 0;
      w_delay  = (k == 0) ? 0 : 3;
      d = $urandom;
      a0 = awv_hi; w0 = wv_hi; b0 = bready_hi;
      do_cmd(1'b1, 32'h28 + 32'(4 * k), 3'b000, d, 4'hF, 0, rd, rs, lat, ok);
      ref_mem[10 + k] = ref_merge(ref_mem[10 + k], d, 4'hF);
      compared++;
      if (awv_hi - a0 !== 1 + aw_delay || wv_hi - w0 !== 1 + w_delay) begin
        mismatched++;
        $display("FAIL order%0d_valid_cycles: aw=%0d w=%0d expected %0d/%0d",
                 k, awv_hi - a0, wv_hi - w0, 1 + aw_delay, 1 + w_delay);
      end
      compared++;
      if (bready_hi - b0 !== 1) begin
        mismatched++; $display("FAIL order%0d_bready: got %0d cycles expected 1", k, bready_hi - b0);
      end
      compared++;
      if (!ok || lat !== 6 || rs !== 2'd0 || s_wdata !== d) begin
        mismatched++;
        $display("FAIL order%0d_rsp: ok=%0d lat=%0d resp=%0d wdata=%h expected 1/6/0/%h",
                 k, ok, lat, rs, s_wdata, d);
      end
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_slverr_hold();
    int acc;
    int n;
    slv_bresp = 2'd2;
    do_cmd(1'b1, 32'h20, 3'b000, 32'hA5A5_0F0F, 4'b0011, -1, rd, rs, lat, ok);
    ref_mem[8] = ref_merge(ref_mem[8], 32'hA5A5_0F0F, 4'b0011);
    slv_bresp = 2'd0;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL slverr_timeout: ok=%0d expected 1", ok); end
    // a new read is waiting while the error response sits unconsumed
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_prot = 3'b000;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({rsp_valid, rsp_resp, cmd_ready} !== 4'b1100) begin
        mismatched++;
        $display("FAIL slverr_hold%0d: valid=%b resp=%0d cmd_ready=%b expected 1/2/0",
                 i, rsp_valid, rsp_resp, cmd_ready);
      end
      @(negedge ACLK);
    end
    rsp_ready = 1'b1;
    compared++;
    if (cmd_ready !== 1'b0) begin
      mismatched++; $display("FAIL slverr_same_cycle: cmd_ready=%b expected 0", cmd_ready);
    end
    @(negedge ACLK);
    rsp_ready = 1'b0;
    compared++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL slverr_next_accept: cmd_ready=%b rsp_valid=%b expected 1/0", cmd_ready, rsp_valid);
    end
    acc = cyc;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge ACLK); n++; end
    compared++;
    if (rsp_valid !== 1'b1 || cyc - acc !== 3 || rsp_rdata !== ref_mem[4] || rsp_resp !== 2'd0) begin
      mismatched++;
      $display("FAIL slverr_followup: valid=%b lat=%0d data=%h resp=%0d expected 1/3/%h/0",
               rsp_valid, cyc - acc, rsp_rdata, rsp_resp, ref_mem[4]);
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int n;
    r_delay = 30;
    @(negedge ACLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14; cmd_prot = 3'b000;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (RREADY !== 1'b1 && n < 20) begin @(negedge ACLK); n++; end
    compared++;
    if (RREADY !== 1'b1) begin mismatched++; $display("FAIL rstmid_reach_rd_r: RREADY=%b expected 1", RREADY); end
    #2 ARESET = 1'b1;
    #1;
    compared++;
    if ({ARVALID, RREADY, rsp_valid} !== 3'b000) begin
      mismatched++;
      $display("FAIL rstmid_async_drop: ARVALID/RREADY/rsp_valid=%b expected 000", {ARVALID, RREADY, rsp_valid});
    end
    @(negedge ACLK);
    ARESET = 1'b0;
    r_delay = 0;
    #1;
    compared++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      mismatched++; $display("FAIL rstmid_release: cmd_ready=%b rsp_valid=%b expected 1/0", cmd_ready, rsp_valid);
    end
    do_cmd(1'b0, 32'h14, 3'b000, 32'h0, 4'h0, 0, rd, rs, lat, ok);
    compared++;
    if (!ok || lat !== 3 || rd !== ref_mem[5] || rs !== 2'd0) begin
      mismatched++;
      $display("FAIL rstmid_next_read: ok=%0d lat=%0d data=%h resp=%0d expected 1/3/%h/0",
               ok, lat, rd, rs, ref_mem[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic        q_wr   [8];
    logic [31:0] q_addr [8];
    logic [31:0] q_data [8];
    logic [3:0]  q_strb [8];
    logic [1:0]  q_resp [8];
    logic [2:0]  q_prot [8];
    logic [31:0] exp_rd [$];
    logic [1:0]  exp_rs [$];
    logic [31:0] e_rd;
    logic [1:0]  e_rs;
    int          ix;
    // expected responses come from the reference memory, in issue order
    for (int i = 0; i < 8; i++) begin
      q_wr[i]   = 1'($urandom_range(0, 1));
      ix        = int'($urandom_range(0, 15));
      q_addr[i] = 32'(ix * 4);
      q_data[i] = $urandom;
      q_strb[i] = 4'($urandom_range(0, 15));
      q_resp[i] = 2'($urandom_range(0, 3));
      q_prot[i] = 3'($urandom_range(0, 7));
      if (q_wr[i]) begin
        ref_mem[ix] = ref_merge(ref_mem[ix], q_data[i], q_strb[i]);
        exp_rd.push_back(32'h0);
      end else begin
        exp_rd.push_back(ref_mem[ix]);
      end
      exp_rs.push_back(q_resp[i]);
    end
    for (int i = 0; i < 8; i++) begin
      aw_delay = int'($urandom_range(0, 3)); w_delay = int'($urandom_range(0, 3));
      ar_delay = int'($urandom_range(0, 3)); b_delay = int'($urandom_range(0, 3));
      r_delay  = int'($urandom_range(0, 3));
      slv_bresp = q_resp[i]; slv_rresp = q_resp[i];
      do_cmd(q_wr[i], q_addr[i], q_prot[i], q_data[i], q_strb[i], int'($urandom_range(0, 2)),
             rd, rs, lat, ok);
      e_rd = exp_rd.pop_front();
      e_rs = exp_rs.pop_front();
      compared++;
      if (!ok || rd !== e_rd) begin
        mismatched++; $display("FAIL b2b%0d_rdata: ok=%0d got %h expected %h", i, ok, rd, e_rd);
      end
      compared++;
      if (rs !== e_rs) begin
        mismatched++; $display("FAIL b2b%0d_resp: got %0d expected %0d", i, rs, e_rs);
      end
    end
    aw_delay = 0; w_delay = 0; ar_delay = 0; b_delay = 0; r_delay = 0;
    slv_bresp = 2'd0; slv_rresp = 2'd0;
    @(negedge ACLK);
    compared++;
    if (viol !== 0) begin
      mismatched++; $display("FAIL protocol_violations: got %0d expected 0", viol);
    end
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_prot = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_stall();
    test_aw_w_order();
    test_slverr_hold();
    test_reset_mid_read();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded bound", $time);
    $fatal(1);
  end

endmodule
